mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester round-robin arbiter feeding a shift-add multiplier
//
// Accepts an operand pair from one of two requesters (valid/ready), multiplies
// it with one shift-add step per cycle over WIDTH cycles, and presents the
// exact 2*WIDTH-bit product with the owner id until the consumer takes it.
//
// Parameters:
//   WIDTH         operand width; product is 2*WIDTH bits
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req0_valid    requester 0 has an operand pair
//   req0_a/b      requester 0 operands
//   req0_ready    requester 0 pair accepted this cycle
//   req1_valid    requester 1 has an operand pair
//   req1_a/b      requester 1 operands
//   req1_ready    requester 1 pair accepted this cycle
//   rsp_valid     result available (DONE)
//   rsp_id        requester owning the result
//   rsp_product   unsigned product
//   rsp_ready     consumer takes the result
// Build option:
//   MULT_ARB_ZERO_SKIP_EN  a zero operand goes straight to DONE with product 0

module mult_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_product,
    input  logic               rsp_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 prio;        // requester favoured when both are valid
    logic                 id_q;
    logic [2*WIDTH-1:0]   mcand_q;     // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier_q;    // multiplier, shifted right each step
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [CW-1:0]        cnt_q;
    logic                 grant_id;
    logic                 accept;
    logic                 last_step;
    logic                 zero_hit;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;

    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = prio;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    // rst_n gating keeps both readys low while reset is held, even with valid high
    assign req0_ready = rst_n && accept && !grant_id;
    assign req1_ready = rst_n && accept && grant_id;

    assign op_a      = grant_id ? req1_a : req0_a;
    assign op_b      = grant_id ? req1_b : req0_b;
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign rsp_valid = (state == DONE);

`ifdef MULT_ARB_ZERO_SKIP_EN
    assign zero_hit = (op_a == '0) || (op_b == '0);
`else
    assign zero_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = zero_hit ? DONE : BUSY;
            BUSY: if (last_step) state_nxt = DONE;
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= 1'b0;
            id_q        <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            rsp_product <= '0;
            rsp_id      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q     <= grant_id;
                        prio     <= !grant_id;
                        mcand_q  <= {{WIDTH{1'b0}}, op_a};
                        mplier_q <= op_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        if (zero_hit) begin
                            rsp_product <= '0;
                            rsp_id      <= grant_id;
                        end
                    end
                end
                BUSY: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    // result registers only change on DONE entry so they hold elsewhere
                    if (last_step) begin
                        rsp_product <= acc_sum;
                        rsp_id      <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
